// File: rtl/boot_store.sv
// Patchable boot memory: parameter image on reset, lockable writes, modular checksum sequencer.
// Latency: read data and rvalid one cycle after cs; checksum takes 2**AW cycles.
// Backpressure: none; bus accesses while busy are dropped (writes flag wr_err). Parity: BOOT_STORE_PARITY_EN.
module boot_store #(
  parameter int DW = 16,
  parameter int AW = 5,
  parameter logic [DW*(2**AW)-1:0] INIT_IMAGE = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          rvalid,
  input  logic          lock_set,
  output logic          locked,
  output logic          wr_err,
  input  logic          csum_start,
  output logic          busy,
  output logic [DW-1:0] csum,
  output logic          csum_done,
  output logic          perr
);
  localparam int DEPTH = 2**AW;

  typedef enum logic [1:0] {IDLE, SUM, DONE} state_t;

  state_t        state;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic [DW-1:0] acc;
  logic          rd_ok;
  logic          wr_ok;
  logic          wr_rej;
  logic          go;
  logic          last;

  // busy and locked are registered, so an access in the csum_start cycle still executes
  assign rd_ok  = cs && !we && !busy;
  assign wr_ok  = cs && we && !locked && !busy;
  assign wr_rej = cs && we && (locked || busy);
  assign go     = (state != SUM) && csum_start;
  assign last   = (state == SUM) && (&idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_IMAGE[i*DW +: DW];
      dout      <= '0;
      rvalid    <= 1'b0;
      locked    <= 1'b0;
      wr_err    <= 1'b0;
      busy      <= 1'b0;
      csum      <= '0;
      csum_done <= 1'b0;
      idx       <= '0;
      acc       <= '0;
      state     <= IDLE;
    end else begin
      rvalid <= rd_ok;
      if (rd_ok) dout <= mem[addr];
      wr_err <= wr_rej;
      if (wr_ok) mem[addr] <= din;
      if (lock_set) locked <= 1'b1;

      case (state)
        IDLE, DONE: begin
          if (csum_start) begin
            state     <= SUM;
            busy      <= 1'b1;
            idx       <= '0;
            acc       <= '0;
            csum_done <= 1'b0;
          end
        end
        SUM: begin
          acc <= acc + mem[idx];
          idx <= idx + 1'b1;
          if (&idx) begin
            csum      <= acc + mem[idx];
            state     <= DONE;
            busy      <= 1'b0;
            csum_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BOOT_STORE_PARITY_EN
  logic mem_par [DEPTH];
  logic sum_err;
  logic mm_rd;
  logic mm_sum;

  assign mm_rd  = (^mem[addr]) ^ mem_par[addr];
  assign mm_sum = (^mem[idx]) ^ mem_par[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_par[i] <= ^INIT_IMAGE[i*DW +: DW];
      sum_err <= 1'b0;
      perr    <= 1'b0;
    end else begin
      if (wr_ok) mem_par[addr] <= ^din;
      if (go) sum_err <= 1'b0;
      else if (state == SUM) sum_err <= sum_err | mm_sum;
      // The sticky pass error is reported only in the first DONE cycle
      if (last) perr <= sum_err | mm_sum;
      else if (rd_ok) perr <= mm_rd;
      else perr <= 1'b0;
    end
  end
`else
  assign perr = 1'b0;
`endif

endmodule
